// File: rtl/sisc_pkg.sv
// Shared SISC definitions: default widths, status flag bit positions and
// the PC/branch select encodings used by the control FSM and the PC stage.
package sisc_pkg;

  localparam int unsigned PC_W_DEF   = 16;
  localparam int unsigned OFF_W_DEF  = 16;
  localparam int unsigned STAT_W_DEF = 4;

  localparam int unsigned STAT_C = 3;
  localparam int unsigned STAT_V = 2;
  localparam int unsigned STAT_N = 1;
  localparam int unsigned STAT_Z = 0;

  typedef enum logic {
    BR_REL = 1'b0,
    BR_ABS = 1'b1
  } br_sel_e;

  typedef enum logic {
    PC_INC = 1'b0,
    PC_BR  = 1'b1
  } pc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the control FSM (master) and the PC stage (slave).
interface pc_unit_if #(
  parameter int unsigned PC_W   = sisc_pkg::PC_W_DEF,
  parameter int unsigned OFF_W  = sisc_pkg::OFF_W_DEF,
  parameter int unsigned STAT_W = sisc_pkg::STAT_W_DEF
);

  logic              pc_rst;
  logic              pc_write;
  logic              pc_sel;
  logic              br_sel;
  logic [OFF_W-1:0]  br_field;
  logic [STAT_W-1:0] stat_in;
  logic              stat_en;

  logic [PC_W-1:0]   pc_out;
  logic [PC_W-1:0]   br_addr;
  logic [STAT_W-1:0] stat_out;
  logic              br_taken;

  modport master (
    output pc_rst, pc_write, pc_sel, br_sel, br_field, stat_in, stat_en,
    input  pc_out, br_addr, stat_out, br_taken
  );

  modport slave (
    input  pc_rst, pc_write, pc_sel, br_sel, br_field, stat_in, stat_en,
    output pc_out, br_addr, stat_out, br_taken
  );

endinterface

// File: rtl/pc_unit_br_calc.sv
// Branch target: absolute (zero-extended field) or PC-relative (PC + field).
// PC_REL_SEXT_EN: sign-extend the field for relative branches (backward branches).
module br_calc
  import sisc_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned OFF_W = OFF_W_DEF
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] br_field,
  input  logic             br_sel,
  output logic [PC_W-1:0]  br_addr_c
);

  logic [PC_W-1:0] abs_ext;
  logic [PC_W-1:0] rel_ext;

  always_comb begin
    abs_ext = PC_W'(br_field);
`ifdef PC_REL_SEXT_EN
    rel_ext = PC_W'($signed(br_field));
`else
    rel_ext = PC_W'(br_field);
`endif
    // PC already points past the branch instruction, so no extra +1 here
    if (br_sel_e'(br_sel) == BR_ABS) begin
      br_addr_c = abs_ext;
    end else begin
      br_addr_c = pc + rel_ext;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter and status register stage; branch target from br_calc.
// Optional macro PC_REL_SEXT_EN selects signed relative branch offsets.
module pc_unit
  import sisc_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned OFF_W  = OFF_W_DEF,
  parameter int unsigned STAT_W = STAT_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  pc_unit_if.slave bus
);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [STAT_W-1:0] stat_q, stat_d;
  logic              br_taken_q, br_taken_d;
  logic [PC_W-1:0]   br_addr_c;

  br_calc #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_br_calc (
    .pc        (pc_q),
    .br_field  (bus.br_field),
    .br_sel    (bus.br_sel),
    .br_addr_c (br_addr_c)
  );

  // pc_rst outranks pc_write; the status register is independent of both
  always_comb begin
    pc_d       = pc_q;
    br_taken_d = 1'b0;
    stat_d     = stat_q;
    if (bus.pc_rst) begin
      pc_d = '0;
    end else if (bus.pc_write) begin
      if (pc_sel_e'(bus.pc_sel) == PC_BR) begin
        pc_d       = br_addr_c;
        br_taken_d = 1'b1;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end
    if (bus.stat_en) begin
      stat_d = bus.stat_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      stat_q     <= '0;
      br_taken_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      stat_q     <= stat_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign bus.pc_out   = pc_q;
  assign bus.br_addr  = br_addr_c;
  assign bus.stat_out = stat_q;
  assign bus.br_taken = br_taken_q;

endmodule
